// File: rtl/ysyx_22050710_mem_req_arbiter_pkg.sv
// Shared types for the IFU/LSU request arbiter: FSM states, owner IDs and
// the two-way round-robin pick.
package ysyx_22050710_mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  // LSU wins when it is alone, or on a conflict when IF was not last granted's loser.
  function automatic logic pick_mem(input logic if_req, input logic mem_req,
                                    input logic last_owner);
    return mem_req & (~if_req | (last_owner == OWNER_IF));
  endfunction

endpackage

// File: rtl/ysyx_22050710_mem_req_arbiter.sv
// Two-master (IFU/LSU) arbiter feeding the AXI master wrapper's single rw port:
// grant, latch, issue one rw_req pulse, hold fields until data_ok, route completion.
module ysyx_22050710_mem_req_arbiter
  import ysyx_22050710_mem_req_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_aclk,
  input  logic                  i_arsetn,
  input  logic                  i_if_req,
  input  logic [1:0]            i_if_size,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_addr_ok,
  output logic                  o_if_data_ok,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_mem_req,
  input  logic                  i_mem_wr,
  input  logic [1:0]            i_mem_size,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [STRB_WIDTH-1:0] i_mem_wstrb,
  input  logic [DATA_WIDTH-1:0] i_mem_wdata,
  output logic                  o_mem_addr_ok,
  output logic                  o_mem_data_ok,
  output logic [DATA_WIDTH-1:0] o_mem_rdata,
  output logic                  o_rw_req,
  output logic                  o_rw_wr,
  output logic [1:0]            o_rw_size,
  output logic [ADDR_WIDTH-1:0] o_rw_addr,
  output logic [STRB_WIDTH-1:0] o_rw_wstrb,
  output logic [DATA_WIDTH-1:0] o_rw_wdata,
  input  logic                  i_rw_data_ok,
  input  logic [DATA_WIDTH-1:0] i_rw_rdata
);

  arb_state_e            state_q;
  logic                  last_q;
  logic                  owner_q;
  logic                  rw_req_q;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic grant_any, grant_mem, grant_if, done;

  always_comb begin
    grant_any = (state_q == ST_IDLE) & (i_if_req | i_mem_req);
    grant_mem = grant_any & pick_mem(i_if_req, i_mem_req, last_q);
    grant_if  = grant_any & ~grant_mem;
    done      = (state_q == ST_WAIT) & i_rw_data_ok;
  end

  // Handshakes are forced low while reset is asserted.
  assign o_if_addr_ok  = i_arsetn & grant_if;
  assign o_mem_addr_ok = i_arsetn & grant_mem;
  assign o_if_data_ok  = i_arsetn & done & (owner_q == OWNER_IF);
  assign o_mem_data_ok = i_arsetn & done & (owner_q == OWNER_MEM);
  assign o_if_rdata    = i_rw_rdata;
  assign o_mem_rdata   = i_rw_rdata;

  assign o_rw_req   = rw_req_q;
  assign o_rw_wr    = wr_q;
  assign o_rw_size  = size_q;
  assign o_rw_addr  = addr_q;
  assign o_rw_wstrb = wstrb_q;
  assign o_rw_wdata = wdata_q;

  always_ff @(posedge i_aclk) begin
    if (!i_arsetn) begin
      state_q  <= ST_IDLE;
      last_q   <= OWNER_IF;
      owner_q  <= OWNER_IF;
      rw_req_q <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rw_req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_mem) begin
            state_q  <= ST_ISSUE;
            last_q   <= OWNER_MEM;
            owner_q  <= OWNER_MEM;
            rw_req_q <= 1'b1;
            wr_q     <= i_mem_wr;
            size_q   <= i_mem_size;
            addr_q   <= i_mem_addr;
            wstrb_q  <= i_mem_wstrb;
            wdata_q  <= i_mem_wdata;
          end else if (grant_if) begin
            state_q  <= ST_ISSUE;
            last_q   <= OWNER_IF;
            owner_q  <= OWNER_IF;
            rw_req_q <= 1'b1;
            wr_q     <= 1'b0;
            size_q   <= i_if_size;
            addr_q   <= i_if_addr;
            wstrb_q  <= '0;
            wdata_q  <= '0;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT:  if (i_rw_data_ok) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_mem_req_arbiter.sv
// Scoreboard bench for the IFU/LSU request arbiter: stimulus queues expected
// grants, downstream requests and completions; a negedge monitor checks them.
module tb_ysyx_22050710_mem_req_arbiter;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 8;

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] rdata;
  } cmp_t;

  logic clk = 1'b0;
  logic rstn;
  logic if_req, mem_req, mem_wr, rw_data_ok;
  logic [1:0] if_size, mem_size;
  logic [AW-1:0] if_addr, mem_addr;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_wdata, rw_rdata;
  logic if_addr_ok, if_data_ok, mem_addr_ok, mem_data_ok;
  logic [DW-1:0] if_rdata, mem_rdata;
  logic rw_req, rw_wr;
  logic [1:0] rw_size;
  logic [AW-1:0] rw_addr;
  logic [SW-1:0] rw_wstrb;
  logic [DW-1:0] rw_wdata;

  int n_chk = 0;
  int n_fail = 0;

  logic grant_q[$];
  req_t req_q[$];
  cmp_t cmp_q[$];

  always #5 clk = ~clk;

  ysyx_22050710_mem_req_arbiter dut (
    .i_aclk(clk), .i_arsetn(rstn),
    .i_if_req(if_req), .i_if_size(if_size), .i_if_addr(if_addr),
    .o_if_addr_ok(if_addr_ok), .o_if_data_ok(if_data_ok), .o_if_rdata(if_rdata),
    .i_mem_req(mem_req), .i_mem_wr(mem_wr), .i_mem_size(mem_size),
    .i_mem_addr(mem_addr), .i_mem_wstrb(mem_wstrb), .i_mem_wdata(mem_wdata),
    .o_mem_addr_ok(mem_addr_ok), .o_mem_data_ok(mem_data_ok), .o_mem_rdata(mem_rdata),
    .o_rw_req(rw_req), .o_rw_wr(rw_wr), .o_rw_size(rw_size), .o_rw_addr(rw_addr),
    .o_rw_wstrb(rw_wstrb), .o_rw_wdata(rw_wdata),
    .i_rw_data_ok(rw_data_ok), .i_rw_rdata(rw_rdata)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic req_t cur_rw();
    req_t r;
    r.wr = rw_wr; r.size = rw_size; r.addr = rw_addr; r.wstrb = rw_wstrb; r.wdata = rw_wdata;
    return r;
  endfunction

  // Monitor: every presented handshake must match the head of its queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (if_addr_ok && mem_addr_ok) chk("dual_addr_ok", 128'd1, 128'd0);
      if (if_addr_ok || mem_addr_ok) begin
        if (grant_q.size() == 0) chk("unexpected_grant", {127'd0, mem_addr_ok}, 128'h2);
        else chk("grant_owner", {127'd0, mem_addr_ok}, {127'd0, grant_q.pop_front()});
      end
      if (rw_req) begin
        if (req_q.size() == 0) chk("unexpected_rw_req", 128'd1, 128'd0);
        else chk("rw_fields", 128'(cur_rw()), 128'(req_q.pop_front()));
      end
      if (if_data_ok || mem_data_ok) begin
        if (cmp_q.size() == 0) chk("unexpected_data_ok", {126'd0, mem_data_ok, if_data_ok}, 128'd0);
        else begin
          cmp_t c;
          c = cmp_q.pop_front();
          chk("data_ok_owner", {126'd0, mem_data_ok, if_data_ok},
              c.owner ? 128'd2 : 128'd1);
          chk("rdata", c.owner ? 128'(mem_rdata) : 128'(if_rdata), 128'(c.rdata));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (if_addr_ok || mem_addr_ok) break;
      n++;
      if (n > 20) begin
        chk({name, "_grant_timeout"}, 128'd0, 128'd1);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Serve one granted request: ISSUE, lat WAIT cycles with stability checks, data_ok.
  task automatic serve(input req_t exp, input int lat, input logic [DW-1:0] rd,
                       input logic stray, input logic drop_reqs);
    tick();
    if (drop_reqs) begin
      if_req = 0; mem_req = 0;
      mem_addr = 32'hFFFF_0000; mem_wdata = '1; mem_wstrb = 8'hFF; mem_wr = 0; mem_size = 2'd0;
    end
    if (stray) begin
      rw_data_ok = 1;
      @(negedge clk);
      chk("stray_issue_no_data_ok", {126'd0, if_data_ok, mem_data_ok}, 128'd0);
      tick();
      rw_data_ok = 0;
    end else tick();
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wait_fields_stable", 128'(cur_rw()), 128'(exp));
      chk("wait_no_rw_req", {127'd0, rw_req}, 128'd0);
      tick();
    end
    rw_data_ok = 1; rw_rdata = rd;
    @(negedge clk);
    chk("done_fields_stable", 128'(cur_rw()), 128'(exp));
    tick();
    rw_data_ok = 0; rw_rdata = '0;
  endtask

  initial begin
    req_t r_if, r_mem, r_if2;
    rstn = 0; if_req = 1; mem_req = 1; if_size = 2; if_addr = 32'h8000_0000;
    mem_wr = 1; mem_size = 3; mem_addr = 32'h8000_1000; mem_wstrb = 8'h0F;
    mem_wdata = 64'h1122_3344; rw_data_ok = 0; rw_rdata = '0;
    tick(); tick();
    // Reset state with both requests asserted.
    @(negedge clk);
    chk("rst_addr_ok", {126'd0, if_addr_ok, mem_addr_ok}, 128'd0);
    chk("rst_rw", {1'b0, rw_req, 128'(cur_rw())} , 128'd0);
    if_req = 0; mem_req = 0;
    tick(); rstn = 1; tick();

    // IFU read alone.
    r_if = '{wr: 1'b0, size: 2'd2, addr: 32'h8000_0000, wstrb: '0, wdata: '0};
    grant_q.push_back(1'b0); req_q.push_back(r_if);
    cmp_q.push_back('{owner: 1'b0, rdata: 64'hDEAD_BEEF});
    if_req = 1;
    wait_grant("if_read");
    serve(r_if, 2, 64'hDEAD_BEEF, 1'b0, 1'b1);

    // LSU write; inputs scrambled after addr_ok must not leak into o_rw_*.
    r_mem = '{wr: 1'b1, size: 2'd3, addr: 32'h8000_1000, wstrb: 8'h0F, wdata: 64'h1122_3344};
    grant_q.push_back(1'b1); req_q.push_back(r_mem);
    cmp_q.push_back('{owner: 1'b1, rdata: 64'h0});
    mem_wr = 1; mem_size = 3; mem_addr = 32'h8000_1000; mem_wstrb = 8'h0F; mem_wdata = 64'h1122_3344;
    mem_req = 1;
    wait_grant("lsu_write");
    serve(r_mem, 3, 64'h0, 1'b0, 1'b1);

    // Stray completion in IDLE, then in ISSUE.
    rw_data_ok = 1;
    @(negedge clk);
    chk("stray_idle_no_data_ok", {126'd0, if_data_ok, mem_data_ok}, 128'd0);
    tick(); rw_data_ok = 0;
    r_if2 = '{wr: 1'b0, size: 2'd1, addr: 32'h8000_0040, wstrb: '0, wdata: '0};
    grant_q.push_back(1'b0); req_q.push_back(r_if2);
    cmp_q.push_back('{owner: 1'b0, rdata: 64'hCAFE_F00D_0000_0001});
    if_size = 1; if_addr = 32'h8000_0040; if_req = 1;
    wait_grant("stray_txn");
    serve(r_if2, 1, 64'hCAFE_F00D_0000_0001, 1'b1, 1'b1);

    // Reset in WAIT: owner abandoned, later completion ignored.
    grant_q.push_back(1'b0); req_q.push_back(r_if2);
    if_req = 1;
    wait_grant("rst_wait_txn");
    tick(); if_req = 0;
    tick();
    rstn = 0; tick(); rstn = 1;
    @(negedge clk);
    chk("post_rst_outputs", {124'd0, rw_req, if_addr_ok, mem_addr_ok, if_data_ok}, 128'd0);
    chk("post_rst_rw", 128'(cur_rw()), 128'd0);
    tick();
    rw_data_ok = 1;
    @(negedge clk);
    chk("post_rst_no_data_ok", {126'd0, if_data_ok, mem_data_ok}, 128'd0);
    tick(); rw_data_ok = 0;

    // Conflict fairness from reset: MEM, IF, MEM, IF.
    if_size = 2; if_addr = 32'h8000_0100;
    mem_wr = 0; mem_size = 3; mem_addr = 32'h8000_2000; mem_wstrb = 8'hAA; mem_wdata = 64'h55;
    r_if  = '{wr: 1'b0, size: 2'd2, addr: 32'h8000_0100, wstrb: '0, wdata: '0};
    r_mem = '{wr: 1'b0, size: 2'd3, addr: 32'h8000_2000, wstrb: 8'hAA, wdata: 64'h55};
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back(k[0] ? 1'b0 : 1'b1);
      req_q.push_back(k[0] ? r_if : r_mem);
      cmp_q.push_back('{owner: ~k[0], rdata: 64'(k + 100)});
    end
    if_req = 1; mem_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_grant("conflict");
      serve(k[0] ? r_if : r_mem, 1, 64'(k + 100), 1'b0, 1'b0);
      if (k == 3) begin if_req = 0; mem_req = 0; end
    end
    tick(); tick();

    chk("grant_q_drained", 128'(grant_q.size()), 128'd0);
    chk("req_q_drained", 128'(req_q.size()), 128'd0);
    chk("cmp_q_drained", 128'(cmp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
